cbus_arbiter_n: RTL and testbench

Parametrised N-input arbiter for the cache bus (CBus). It sits between the per-port bus converters (instruction side, data side, and any future uncached or DMA port) and the single outgoing `oreq`/`oresp` pair at the top level. It grants one requester at a time and holds the grant for the whole burst, up to the `last` beat. It generalises the fixed two-input mux to N inputs, with selectable round-robin or fixed-priority arbitration and per-port grant observability.

---
 rtl/cbus_arb_pkg.sv | 12 +
 rtl/cbus_pkg.sv | 21 ++
 rtl/cbus_arb_pick.sv | 47 ++++
 rtl/cbus_arbiter_n.sv | 100 ++++++++++
 tb/tb_cbus_arbiter_n.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cbus_arb_pkg.sv
// Shared definitions for the N-input CBus arbiter: FSM state encoding and
// the upper bound on the number of requesters.
package cbus_arb_pkg;

  localparam int unsigned MAX_ARB_INPUTS = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cbus_pkg.sv
// Common cache-bus (CBus) request/response types shared by the bus
// converters, the arbiter and the memory side.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        okay;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arb_pick.sv
// Combinational winner selection for the CBus arbiter. Round-robin from
// rr_ptr_i when CBUS_ARB_ROUND_ROBIN_EN is defined, else lowest index wins.
module cbus_arb_pick #(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid_i,
  input  logic [IDX_W-1:0]      rr_ptr_i,
  output logic                  any_valid_o,
  output logic [IDX_W-1:0]      winner_idx_o
);

  assign any_valid_o = |valid_i;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic             rr_found;
  logic [IDX_W-1:0] rr_cand;

  // Scan upward from the pointer with wrap; first valid index wins.
  always_comb begin
    winner_idx_o = '0;
    rr_found     = 1'b0;
    rr_cand      = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      rr_cand = IDX_W'((int'(rr_ptr_i) + k) % NUM_INPUTS);
      if (!rr_found && valid_i[rr_cand]) begin
        rr_found     = 1'b1;
        winner_idx_o = rr_cand;
      end
    end
  end
`else
  logic [IDX_W-1:0] unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr_i;

  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    winner_idx_o = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (valid_i[IDX_W'(k)]) begin
        winner_idx_o = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/cbus_arbiter_n.sv
// N-input CBus arbiter: grants one requester and holds it until okay&&last.
// Arbitration mode selected by CBUS_ARB_ROUND_ROBIN_EN (see cbus_arb_pick).
module cbus_arbiter_n
  import cbus_pkg::*;
  import cbus_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  // Handshake: a port requests by holding valid; once granted, oreq mirrors
  // that port and oresp is routed back to it until a beat with okay && last.
  // Non-granted ports keep valid asserted and simply wait their turn.

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_INPUTS-1:0] valid_vec;
  logic                  any_valid;
  logic [IDX_W-1:0]      winner_idx;
  logic                  burst_done;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  cbus_arb_pick #(
    .NUM_INPUTS(NUM_INPUTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .valid_i     (valid_vec),
    .rr_ptr_i    (rr_ptr_q),
    .any_valid_o (any_valid),
    .winner_idx_o(winner_idx)
  );

  assign burst_done = oresp.okay && oresp.last;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          state_d     = ARB_BUSY;
          grant_idx_d = winner_idx;
        end
      end
      ARB_BUSY: begin
        if (burst_done) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_INPUTS - 1)) ? '0
                                                             : grant_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign busy      = (state_q == ARB_BUSY);
  assign grant_idx = grant_idx_q;

  // Reset gates the forwarded request immediately so memory sees the burst
  // abandoned in the same cycle reset is sampled.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (busy && !reset) begin
      oreq                = ireqs[grant_idx_q];
      iresps[grant_idx_q] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Self-checking bench for cbus_arbiter_n (NUM_INPUTS=4); expected grant order
// follows CBUS_ARB_ROUND_ROBIN_EN as the RTL build does.
module tb_cbus_arbiter_n;
  import cbus_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk;
  logic          reset;
  cbus_req_t     ireqs  [N];
  cbus_resp_t    iresps [N];
  cbus_req_t     oreq;
  cbus_resp_t    oresp;
  logic          busy;
  logic [IW-1:0] grant_idx;

  int            n_total = 0;
  int            n_bad   = 0;
  logic [3:0]    exp_q[$];
  logic          prev_busy = 1'b0;
  logic [3:0]    mon_e;
  int            w;
  int            order[6];
  int            first_w;

  cbus_arbiter_n #(.NUM_INPUTS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .ireqs    (ireqs),
    .iresps   (iresps),
    .oreq     (oreq),
    .oresp    (oresp),
    .busy     (busy),
    .grant_idx(grant_idx)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---- checking ----
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] port_addr(input int p);
    return 32'h1000_0000 + 32'(p) * 32'h100;
  endfunction

  // ---- driver tasks ----
  task automatic set_req(input int port, input logic wr, input logic [3:0] len);
    cbus_req_t q;
    q.valid    = 1'b1;
    q.is_write = wr;
    q.size     = 3'd2;
    q.addr     = port_addr(port);
    q.strobe   = wr ? 4'hF : 4'h0;
    q.data     = 32'hA5A5_0000 | 32'(port);
    q.len      = len;
    ireqs[port] = q;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_gidx", 128'(grant_idx), 128'(0));
  endtask

  // Wait for a grant to 'port', then play the memory side for n_beats beats.
  // err_beat: that beat carries okay=0,last=1 (must not end the burst).
  // rst_beat: assert reset on that beat instead of completing the burst.
  task automatic serve(input int port, input int n_beats, input int err_beat,
                       input int rst_beat, input logic [3:0] drop_mask, output int waited);
    cbus_resp_t r;
    waited = 0;
    @(negedge clk);
    while (!busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("grant_wait", 128'(busy), 128'(1));
    if (!busy) return;
    check("grant_idx", 128'(grant_idx), 128'(port));
    for (int b = 0; b < n_beats; b++) begin
      r.okay = (b != err_beat);
      r.last = (b == n_beats - 1) || (b == err_beat);
      r.data = 32'hD000_0000 | (32'(port) << 8) | 32'(b);
      oresp  = r;
      if (b == rst_beat) reset = 1'b1;
      #1;
      if (b == rst_beat) begin
        check("rst_oreq_same", 128'(oreq), 128'(0));
        for (int i = 0; i < N; i++) check("rst_iresp_same", 128'(iresps[i]), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        oresp = '0;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_oreq", 128'(oreq), 128'(0));
        check("rst_gidx_mid", 128'(grant_idx), 128'(0));
        return;
      end
      check("beat_busy", 128'(busy), 128'(1));
      check("beat_gidx", 128'(grant_idx), 128'(port));
      check("oreq_fwd", 128'(oreq), 128'(ireqs[port]));
      for (int i = 0; i < N; i++) begin
        if (i == port) check("iresp_grant", 128'(iresps[i]), 128'(r));
        else           check("iresp_other", 128'(iresps[i]), 128'(0));
      end
      @(posedge clk); #1;
      oresp = '0;
      if (b == n_beats - 1) begin
        for (int i = 0; i < N; i++) if (drop_mask[i]) ireqs[i] = '0;
      end
      @(negedge clk);
    end
    check("busy_after_last", 128'(busy), 128'(0));
  endtask

  // ---- scoreboard: pop the expected grantee on every new grant ----
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
      check("sb_grant", 128'(grant_idx), 128'(mon_e));
      if (mon_e != 4'hF) check("sb_addr", 128'(oreq.addr), 128'(port_addr(int'(mon_e))));
    end
    prev_busy = busy;
  end

  // ---- stimulus ----
  initial begin
    reset = 1'b1;
    oresp = '0;
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_gidx", 128'(grant_idx), 128'(0));
    check("reset_oreq", 128'(oreq), 128'(0));
    for (int i = 0; i < N; i++) check("reset_iresp", 128'(iresps[i]), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Single requester, 4-beat read on port 2.
    exp_q.push_back(4'd2);
    set_req(2, 1'b0, 4'd3);
    serve(2, 4, -1, -1, 4'b0100, w);
    check("single_latency", 128'(w), 128'(1));
    check("gidx_hold", 128'(grant_idx), 128'(2));

    // Contention among ports 0, 1, 3 with valids held high.
    do_reset();
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 3, 0, 1, 3};
`else
    order = '{0, 0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 6; k++) exp_q.push_back(4'(order[k]));
    set_req(0, 1'b0, 4'd0);
    set_req(1, 1'b1, 4'd0);
    set_req(3, 1'b0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      serve(order[k], 1, -1, -1, (k == 5) ? 4'b1011 : 4'b0000, w);
      if (k > 0) check("contend_bubble", 128'(w), 128'(0));
    end

    // Late arrival: port 1 raises valid mid-burst of port 0.
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    set_req(0, 1'b0, 4'd7);
    fork
      serve(0, 8, -1, -1, 4'b0001, w);
      begin
        repeat (3) @(posedge clk);
        #1;
        set_req(1, 1'b1, 4'd0);
      end
    join
    serve(1, 1, -1, -1, 4'b0010, w);
    check("late_bubble", 128'(w), 128'(0));

    // Reset on beat 2 of 4; rr pointer must restart at 0 afterwards.
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    first_w = 3;
`else
    first_w = 1;
`endif
    exp_q.push_back(4'(first_w));
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    set_req(1, 1'b0, 4'd3);
    set_req(3, 1'b1, 4'd3);
    serve(first_w, 4, -1, 2, 4'b0000, w);
    serve(1, 4, -1, -1, 4'b0010, w);
    check("post_rst_regrant", 128'(w), 128'(0));
    serve(3, 4, -1, -1, 4'b1000, w);

    // Error pass-through: okay=0 with last=1 must not release the grant.
    exp_q.push_back(4'd2);
    set_req(2, 1'b1, 4'd2);
    serve(2, 3, 1, -1, 4'b0100, w);

    repeat (3) @(negedge clk);
    check("sb_drain", 128'(exp_q.size()), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
